// File: rtl/layer_compositor_pkg.sv
// Shared types and defaults for the layer compositor.
// Provides rgb_t, DEFAULT_COLOR_KEY and DEFAULT_BLINK_FRAMES.
package layer_compositor_pkg;

  localparam int DEFAULT_RGB_W = 8;
  localparam int DEFAULT_BLINK_FRAMES = 30;
  localparam logic [DEFAULT_RGB_W-1:0] DEFAULT_COLOR_KEY = 8'hFF;

  typedef logic [DEFAULT_RGB_W-1:0] rgb_t;

endpackage

// File: rtl/layer_compositor_if.sv
// Pixel bus between the object drawers, compositor and VGA stage.
// master drives layer inputs; slave (compositor) drives the results.
interface layer_compositor_if #(
  parameter int NUM_LAYERS = 16,
  parameter int RGB_W      = 8
);
  localparam int IW = $clog2(NUM_LAYERS);

  logic                        pix_valid_in;
  logic                        frame_start;
  logic [NUM_LAYERS-1:0]       draw_req;
  logic [NUM_LAYERS*RGB_W-1:0] layer_rgb;
  logic [NUM_LAYERS-1:0]       layer_en;
  logic [NUM_LAYERS-1:0]       blink_mask;
  logic [RGB_W-1:0]            bg_rgb;
  logic [RGB_W-1:0]            rgb_out;
  logic                        pix_valid_out;
  logic                        win_hit;
  logic [IW-1:0]               win_layer;
  logic [NUM_LAYERS-1:0]       layer_hits;

  modport master (
    output pix_valid_in, frame_start,
    output draw_req, layer_rgb,
    output layer_en, blink_mask, bg_rgb,
    input  rgb_out, pix_valid_out,
    input  win_hit, win_layer, layer_hits
  );

  modport slave (
    input  pix_valid_in, frame_start,
    input  draw_req, layer_rgb,
    input  layer_en, blink_mask, bg_rgb,
    output rgb_out, pix_valid_out,
    output win_hit, win_layer, layer_hits
  );

endinterface

// File: rtl/layer_priority_encoder.sv
// Combinational priority encoder, lowest set index wins.
// Ports: req in; any = |req; idx = winning index (0 if none).
module layer_priority_encoder #(
  parameter int N = 16,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  output logic          any,
  output logic [IW-1:0] idx
);

  always_comb begin
    any = |req;
    idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) idx = IW'(i);
    end
  end

endmodule

// File: rtl/layer_compositor.sv
// 2-stage priority compositor with enable, blink and hit report.
// Ports: clk, reset (sync, high), bus (slave). COMPOSITOR_COLOR_KEY_EN.
module layer_compositor
  import layer_compositor_pkg::*;
#(
  parameter int NUM_LAYERS   = 16,
  parameter int RGB_W        = 8,
  parameter int BLINK_FRAMES = DEFAULT_BLINK_FRAMES,
  parameter logic [RGB_W-1:0] COLOR_KEY =
    RGB_W'(DEFAULT_COLOR_KEY)
) (
  input logic clk,
  input logic reset,
  layer_compositor_if.slave bus
);

  localparam int IW = $clog2(NUM_LAYERS);
  localparam int CW =
    (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  logic [CW-1:0]               blink_cnt;
  logic                        blink_phase;
  logic [NUM_LAYERS-1:0]       eff_req;

  logic [NUM_LAYERS-1:0]       s1_req;
  logic [NUM_LAYERS*RGB_W-1:0] s1_rgb;
  logic [RGB_W-1:0]            s1_bg;
  logic                        s1_valid;
  logic                        s1_fs;

  logic                        any;
  logic [IW-1:0]               idx;
  logic [NUM_LAYERS-1:0]       cur_hit;
  logic [NUM_LAYERS-1:0]       hit_acc;

`ifdef COMPOSITOR_COLOR_KEY_EN
  logic [NUM_LAYERS-1:0] opaque;
  always_comb begin
    opaque = '0;
    for (int i = 0; i < NUM_LAYERS; i++)
      opaque[i] =
        bus.layer_rgb[i*RGB_W +: RGB_W] != COLOR_KEY;
  end
`else
  logic [NUM_LAYERS-1:0] opaque;
  wire unused_key = ^COLOR_KEY;
  assign opaque = '1;
`endif

  assign eff_req = bus.draw_req & bus.layer_en & opaque
    & ~(bus.blink_mask & {NUM_LAYERS{blink_phase}});

  // Phase flips after the pulse cycle, so that
  // cycle's pixel still sees the old phase.
  always_ff @(posedge clk) begin
    if (reset) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
    end else if (bus.frame_start) begin
      if (blink_cnt == CW'(BLINK_FRAMES - 1)) begin
        blink_cnt   <= '0;
        blink_phase <= ~blink_phase;
      end else begin
        blink_cnt <= blink_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_req   <= '0;
      s1_rgb   <= '0;
      s1_bg    <= '0;
      s1_valid <= 1'b0;
      s1_fs    <= 1'b0;
    end else begin
      s1_req   <= eff_req;
      s1_rgb   <= bus.layer_rgb;
      s1_bg    <= bus.bg_rgb;
      s1_valid <= bus.pix_valid_in;
      s1_fs    <= bus.frame_start;
    end
  end

  layer_priority_encoder #(.N(NUM_LAYERS)) u_enc (
    .req (s1_req),
    .any (any),
    .idx (idx)
  );

  assign cur_hit = (s1_valid && any)
    ? (NUM_LAYERS'(1) << idx) : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      bus.rgb_out       <= '0;
      bus.pix_valid_out <= 1'b0;
      bus.win_hit       <= 1'b0;
      bus.win_layer     <= '0;
      bus.layer_hits    <= '0;
      hit_acc           <= '0;
    end else begin
      bus.rgb_out       <= any
        ? s1_rgb[idx*RGB_W +: RGB_W] : s1_bg;
      bus.pix_valid_out <= s1_valid;
      bus.win_hit       <= any;
      bus.win_layer     <= any ? idx : '0;
      // Report excludes the pixel that rides with the pulse;
      // that pixel opens the new frame's accumulator.
      if (s1_fs) begin
        bus.layer_hits <= hit_acc;
        hit_acc        <= cur_hit;
      end else begin
        hit_acc <= hit_acc | cur_hit;
      end
    end
  end

endmodule

// File: tb/tb_layer_compositor.sv
// Self-checking bench for layer_compositor.
// Directed cases then random traffic against a frame-level model.
module tb_layer_compositor;

  localparam int N  = 16;
  localparam int W  = 8;
  localparam int BF = 2;
  localparam logic [W-1:0] KEY = 8'hFF;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  layer_compositor_if #(.NUM_LAYERS(N), .RGB_W(W)) bus ();

  layer_compositor #(
    .NUM_LAYERS(N), .RGB_W(W),
    .BLINK_FRAMES(BF), .COLOR_KEY(KEY)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  typedef struct {
    logic [W-1:0] rgb;
    logic         hit;
    logic [3:0]   lay;
    logic         v;
    logic         fs;
  } exp_t;

  int tests = 0;
  int fails = 0;
  exp_t prev;
  int fcount;
  logic [N-1:0] acc;
  logic [N-1:0] exp_hits;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, expv);
    end
  endtask

  function automatic exp_t zero_item();
    exp_t e;
    e.rgb = '0; e.hit = 0; e.lay = '0;
    e.v = 0; e.fs = 0;
    return e;
  endfunction

  // Visible while (frames seen / BF) is even.
  function automatic exp_t model_item();
    exp_t e;
    logic [W-1:0] c;
    bit ok;
    bit hidden;
    hidden = ((fcount / BF) % 2) == 1;
    e = zero_item();
    e.rgb = bus.bg_rgb;
    e.v = bus.pix_valid_in;
    e.fs = bus.frame_start;
    for (int i = 0; i < N; i++) begin
      c = bus.layer_rgb[i*W +: W];
      ok = bus.draw_req[i] && bus.layer_en[i]
        && !(bus.blink_mask[i] && hidden);
`ifdef COMPOSITOR_COLOR_KEY_EN
      ok = ok && (c != KEY);
`endif
      if (ok && !e.hit) begin
        e.hit = 1; e.rgb = c; e.lay = 4'(i);
      end
    end
    return e;
  endfunction

  task automatic check_out();
    if (prev.fs) begin
      exp_hits = acc;
      acc = '0;
    end
    if (prev.v && prev.hit) acc[prev.lay] = 1'b1;
    chk("rgb_out", 32'(bus.rgb_out), 32'(prev.rgb));
    chk("win_hit", 32'(bus.win_hit), 32'(prev.hit));
    chk("win_layer", 32'(bus.win_layer), 32'(prev.lay));
    chk("pix_valid_out", 32'(bus.pix_valid_out), 32'(prev.v));
    chk("layer_hits", 32'(bus.layer_hits), 32'(exp_hits));
  endtask

  task automatic step();
    exp_t cur;
    cur = model_item();
    if (bus.frame_start) fcount++;
    @(posedge clk);
    #1;
    check_out();
    prev = cur;
    bus.frame_start = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    prev = zero_item();
    fcount = 0;
    acc = '0;
    exp_hits = '0;
    bus.frame_start = 1'b0;
    chk("rst_rgb", 32'(bus.rgb_out), 0);
    chk("rst_hit", 32'(bus.win_hit), 0);
    chk("rst_layer", 32'(bus.win_layer), 0);
    chk("rst_valid", 32'(bus.pix_valid_out), 0);
    chk("rst_hits", 32'(bus.layer_hits), 0);
    chk("rst_phase", 32'(dut.blink_phase), 0);
  endtask

  task automatic clear_in();
    bus.pix_valid_in = 0; bus.frame_start = 0;
    bus.draw_req = '0; bus.layer_rgb = '0;
    bus.layer_en = '1; bus.blink_mask = '0;
    bus.bg_rgb = '0;
  endtask

  initial begin
    clear_in();
    prev = zero_item();
    fcount = 0; acc = '0; exp_hits = '0;
    do_reset();

    // 1: lowest requesting layer wins
    bus.pix_valid_in = 1;
    bus.draw_req = 16'h0006;
    bus.layer_rgb[1*W +: W] = 8'hE0;
    bus.layer_rgb[2*W +: W] = 8'h1C;
    step();
    bus.draw_req = '0; bus.bg_rgb = 8'h25;
    step();
    chk("t1_rgb", 32'(bus.rgb_out), 32'h E0);
    chk("t1_layer", 32'(bus.win_layer), 1);
    chk("t1_hit", 32'(bus.win_hit), 1);

    // 2: background, valid tracking
    bus.pix_valid_in = 0;
    step();
    chk("t2_rgb", 32'(bus.rgb_out), 32'h25);
    chk("t2_hit", 32'(bus.win_hit), 0);
    chk("t2_valid", 32'(bus.pix_valid_out), 1);
    bus.pix_valid_in = 1;
    step();
    chk("t2_valid0", 32'(bus.pix_valid_out), 0);
    step();

    // 6: colour key on layer 0
    bus.draw_req = 16'h0003;
    bus.layer_rgb[0*W +: W] = 8'hFF;
    bus.layer_rgb[1*W +: W] = 8'h03;
    step();
    step();
`ifdef COMPOSITOR_COLOR_KEY_EN
    chk("t6_rgb", 32'(bus.rgb_out), 32'h03);
    chk("t6_layer", 32'(bus.win_layer), 1);
`else
    chk("t6_rgb", 32'(bus.rgb_out), 32'hFF);
    chk("t6_layer", 32'(bus.win_layer), 0);
`endif

    // 5: disabled layer falls to background, then reset
    bus.draw_req = 16'h0001;
    bus.layer_en = 16'hFFFE;
    bus.bg_rgb = 8'h5A;
    step();
    step();
    chk("t5_rgb", 32'(bus.rgb_out), 32'h5A);
    chk("t5_hit", 32'(bus.win_hit), 0);
    bus.frame_start = 1;
    step();
    do_reset();

    // 3: blinking layer 0 over layer 4
    clear_in();
    bus.blink_mask = 16'h0001;
    bus.draw_req = 16'h0011;
    bus.layer_rgb[0*W +: W] = 8'h11;
    bus.layer_rgb[4*W +: W] = 8'h44;
    for (int f = 0; f < 6; f++) begin
      if (f > 0) begin
        bus.pix_valid_in = 0; bus.frame_start = 1;
        step();
      end
      bus.pix_valid_in = 1;
      for (int p = 0; p < 3; p++) step();
      chk("t3_rgb", 32'(bus.rgb_out),
          ((f / 2) % 2 == 1) ? 32'h44 : 32'h11);
    end

    // 4: hit report 3 and 7, 5 always beaten
    clear_in();
    bus.layer_rgb = {N{8'h77}};
    bus.frame_start = 1;
    step();
    bus.pix_valid_in = 1;
    bus.draw_req = 16'h0028; step();
    bus.draw_req = 16'h0080; step();
    bus.draw_req = 16'h0028; step();
    bus.draw_req = '0;
    bus.pix_valid_in = 0; bus.frame_start = 1;
    step();
    step();
    step();
    chk("t4_hits", 32'(bus.layer_hits), 32'h0088);

    // random traffic with one mid-run reset
    for (int n = 0; n < 2000; n++) begin
      bus.pix_valid_in = ($urandom_range(0, 9) < 8);
      bus.frame_start = ($urandom_range(0, 19) == 0);
      bus.draw_req = 16'($urandom);
      bus.layer_en = 16'($urandom) | 16'($urandom);
      bus.blink_mask = 16'($urandom);
      bus.bg_rgb = 8'($urandom);
      for (int i = 0; i < N; i++)
        bus.layer_rgb[i*W +: W] = ($urandom_range(0, 3) == 0)
          ? KEY : 8'($urandom);
      if (n == 1000) do_reset();
      else step();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
